gray_code_counter: RTL and testbench

- Synchronous up/down counter whose registered output is a WIDTH-bit Gray code.
- Sits directly upstream of the Gray-to-binary converter and drives its g input.
- Every enabled step changes exactly one output bit.
- Also provides parallel load (Gray-coded), a terminal-count flag and change/wrap strobes for downstream sampling.

---
 rtl/gray_code_counter.sv | 82 ++++++++
 tb/tb_gray_code_counter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/gray_code_counter.sv
// Up/down counter with a registered Gray-coded output, parallel Gray load, terminal-count and change/wrap strobes.
// One cycle from en/load to new g; the counter always accepts a request, so there is no backpressure.
module gray_code_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_g,
  output logic [WIDTH-1:0] g,
  output logic             tc,
  output logic             chg,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  logic [WIDTH-1:0] bcnt;
  logic [WIDTH-1:0] bcnt_nxt;
  logic [WIDTH-1:0] g_nxt;
  logic [WIDTH-1:0] load_bin;
  logic             chg_nxt;
  logic             wrap_nxt;
  logic             at_end;

  // Each binary bit is the XOR of all Gray bits at and above it, accumulated from the MSB down.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] b;
    b = ZERO;
    b[WIDTH-1] = x[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ x[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign load_bin = gray_to_bin(load_g);

  // The step about to be taken in the current direction crosses the modulus boundary.
  assign at_end = up ? (bcnt == ALL_ONES) : (bcnt == ZERO);
  assign tc     = en & ~load & at_end;

  always_comb begin
    bcnt_nxt = bcnt;
    g_nxt    = g;
    chg_nxt  = 1'b0;
    wrap_nxt = 1'b0;
    if (load) begin
      bcnt_nxt = load_bin;
      g_nxt    = load_g;
      chg_nxt  = (load_g != g);
    end else if (en) begin
      bcnt_nxt = up ? (bcnt + ONE) : (bcnt - ONE);
      g_nxt    = bin_to_gray(bcnt_nxt);
      chg_nxt  = 1'b1;
      wrap_nxt = at_end;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt <= ZERO;
      g    <= ZERO;
      chg  <= 1'b0;
      wrap <= 1'b0;
    end else begin
      bcnt <= bcnt_nxt;
      g    <= g_nxt;
      chg  <= chg_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed bench for gray_code_counter at WIDTH=4 with hand-computed Gray sequences.
module tb_gray_code_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_g;
  logic [3:0] g;
  logic       tc;
  logic       chg;
  logic       wrap;

  int total = 0;
  int bad   = 0;

  logic [3:0] up_seq [0:16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

  gray_code_counter #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .up     (up),
    .load   (load),
    .load_g (load_g),
    .g      (g),
    .tc     (tc),
    .chg    (chg),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Downstream converter behaviour, used to report the binary value seen after g.
  function automatic logic [3:0] conv(input logic [3:0] x);
    logic [3:0] b;
    b[3] = x[3];
    b[2] = b[3] ^ x[2];
    b[1] = b[2] ^ x[1];
    b[0] = b[1] ^ x[0];
    return b;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_g = 4'b0000;
    step();
    step();
    total++; if (g !== 4'b0000) begin bad++; $display("FAIL reset_g got=%b want=0000", g); end
    total++; if (chg !== 1'b0) begin bad++; $display("FAIL reset_chg got=%b want=0", chg); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", wrap); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL reset_tc got=%b want=0", tc); end
  endtask

  task automatic test_count_up();
    logic [3:0] prev;
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      total++; if (tc !== (up_seq[i] == 4'b1000)) begin bad++; $display("FAIL up_tc step=%0d got=%b want=%b", i, tc, up_seq[i] == 4'b1000); end
      prev = g;
      step();
      total++; if (g !== up_seq[i+1]) begin bad++; $display("FAIL up_g step=%0d got=%b want=%b", i, g, up_seq[i+1]); end
      total++; if ($countones(g ^ prev) != 1) begin bad++; $display("FAIL up_onebit step=%0d got=%b prev=%b want one bit changed", i, g, prev); end
      total++; if (chg !== 1'b1) begin bad++; $display("FAIL up_chg step=%0d got=%b want=1", i, chg); end
      total++; if (wrap !== (i == 15)) begin bad++; $display("FAIL up_wrap step=%0d got=%b want=%b", i, wrap, i == 15); end
    end
  endtask

  task automatic test_count_down();
    rst = 1'b1; en = 1'b0; load = 1'b0;
    step();
    rst = 1'b0; en = 1'b1; up = 1'b0;
    #1;
    total++; if (tc !== 1'b1) begin bad++; $display("FAIL down_tc_at_zero got=%b want=1", tc); end
    step();
    total++; if (g !== 4'b1000) begin bad++; $display("FAIL down_g1 got=%b want=1000", g); end
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL down_wrap1 got=%b want=1", wrap); end
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL down_tc_after got=%b want=0", tc); end
    step();
    total++; if (g !== 4'b1001) begin bad++; $display("FAIL down_g2 got=%b want=1001", g); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL down_wrap2 got=%b want=0", wrap); end
    total++; if (chg !== 1'b1) begin bad++; $display("FAIL down_chg2 got=%b want=1", chg); end
  endtask

  task automatic test_load();
    load = 1'b1; load_g = 4'b1010; en = 1'b1; up = 1'b0;
    #1;
    total++; if (tc !== 1'b0) begin bad++; $display("FAIL load_tc_masked got=%b want=0", tc); end
    step();
    total++; if (g !== 4'b1010) begin bad++; $display("FAIL load_g got=%b want=1010", g); end
    total++; if (chg !== 1'b1) begin bad++; $display("FAIL load_chg got=%b want=1", chg); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL load_wrap got=%b want=0", wrap); end
    load = 1'b0;
    step();
    total++; if (g !== 4'b1110) begin bad++; $display("FAIL load_dn1 got=%b want=1110", g); end
    total++; if (chg !== 1'b1) begin bad++; $display("FAIL load_dn1_chg got=%b want=1", chg); end
    step();
    total++; if (g !== 4'b1111) begin bad++; $display("FAIL load_dn2 got=%b want=1111", g); end
    total++; if (chg !== 1'b1) begin bad++; $display("FAIL load_dn2_chg got=%b want=1", chg); end
  endtask

  task automatic test_load_same_and_hold();
    en = 1'b0; load = 1'b1; load_g = 4'b0110;
    step();
    total++; if (g !== 4'b0110) begin bad++; $display("FAIL same_first got=%b want=0110", g); end
    step();
    total++; if (g !== 4'b0110) begin bad++; $display("FAIL same_g got=%b want=0110", g); end
    total++; if (chg !== 1'b0) begin bad++; $display("FAIL same_chg got=%b want=0", chg); end
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (g !== 4'b0110) begin bad++; $display("FAIL hold_g cyc=%0d got=%b want=0110", i, g); end
      total++; if (chg !== 1'b0 || wrap !== 1'b0) begin bad++; $display("FAIL hold_strobes cyc=%0d got chg=%b wrap=%b want 0 0", i, chg, wrap); end
    end
    // Counting resumes from the loaded value: 0110 is binary 4, next up is 5 -> 0111.
    en = 1'b1; up = 1'b1;
    step();
    total++; if (g !== 4'b0111) begin bad++; $display("FAIL after_load_up got=%b want=0111", g); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; en = 1'b0; load = 1'b0;
    step();
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 5; i++) step();
    total++; if (g !== 4'b0111) begin bad++; $display("FAIL mid_pre got=%b want=0111", g); end
    rst = 1'b1; load = 1'b1; load_g = 4'b1111;
    step();
    total++; if (g !== 4'b0000) begin bad++; $display("FAIL mid_rst_g got=%b want=0000", g); end
    total++; if (chg !== 1'b0 || wrap !== 1'b0) begin bad++; $display("FAIL mid_rst_strobes got chg=%b wrap=%b want 0 0", chg, wrap); end
    rst = 1'b0; load = 1'b0;
    step();
    total++; if (g !== 4'b0001) begin bad++; $display("FAIL mid_resume got=%b want=0001", g); end
    total++; if (chg !== 1'b1) begin bad++; $display("FAIL mid_resume_chg got=%b want=1", chg); end
  endtask

  task automatic test_direction();
    logic [3:0] exp_g [0:3] = '{4'b0100, 4'b0101, 4'b0100, 4'b0101};
    logic [3:0] exp_b [0:3] = '{4'd7, 4'd6, 4'd7, 4'd6};
    en = 1'b0; load = 1'b1; load_g = 4'b0101;
    step();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up = (i % 2 == 0);
      step();
      total++; if (g !== exp_g[i]) begin bad++; $display("FAIL dir_g cyc=%0d got=%b want=%b", i, g, exp_g[i]); end
      total++; if (conv(g) !== exp_b[i]) begin bad++; $display("FAIL dir_bin cyc=%0d got=%0d want=%0d", i, conv(g), exp_b[i]); end
      total++; if (chg !== 1'b1) begin bad++; $display("FAIL dir_chg cyc=%0d got=%b want=1", i, chg); end
    end
    en = 1'b0;
    step();
    total++; if (chg !== 1'b0) begin bad++; $display("FAIL dir_chg_drop got=%b want=0", chg); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_load_same_and_hold();
    test_reset_mid();
    test_direction();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
